count_seq_monitor: RTL and testbench

//  Receive-side checker for a free-running binary up-counter bus. Samples the

---
 rtl/count_seq_monitor_if.sv | 24 ++
 rtl/count_seq_monitor.sv | 108 ++++++++++
 tb/tb_count_seq_monitor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_monitor_if.sv
// Bus between a free-running up-counter and its receive-side sequence monitor.
// The counter side drives sample_en/count_in; the monitor returns its status.
interface count_seq_monitor_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic             sample_en;
    logic [WIDTH-1:0] count_in;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] expected;
    logic             fault;

    modport master (
        output sample_en, count_in,
        input  locked, err_pulse, err_count, expected, fault
    );

    modport slave (
        input  sample_en, count_in,
        output locked, err_pulse, err_count, expected, fault
    );
endinterface

// File: rtl/count_seq_monitor.sv
// Locks onto a +1 (mod 2^WIDTH) count sequence and flags/counts broken steps.
// Define CNTMON_STICKY_FAULT_EN to make a locked mismatch a sticky fault until clear.
module count_seq_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input logic              clock,
    input logic              clear,
    count_seq_monitor_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [WIDTH-1:0] expected_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_count_q;

    logic [WIDTH-1:0] next_expected;
    logic [RUN_W-1:0] run_inc;
    logic             match;

    // Wrap from all-ones to zero is a correct step, so the carry is discarded.
    assign next_expected = bus.count_in + WIDTH'(1);
    assign run_inc       = run + RUN_W'(1);
    assign match         = (bus.count_in == expected_q);

`ifdef CNTMON_STICKY_FAULT_EN
    logic fault_q;
`endif

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments everywhere here so every register sees pre-edge values.
        if (clear) begin
            state       <= IDLE;
            run         <= '0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
`ifdef CNTMON_STICKY_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.sample_en) begin
                case (state)
                    IDLE: begin
                        expected_q <= next_expected;
                        run        <= '0;
                        state      <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        expected_q <= next_expected;
                        if (!match) begin
                            run <= '0;
                        end else if (run_inc == RUN_TARGET) begin
                            run      <= '0;
                            locked_q <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    LOCKED: begin
                        expected_q <= next_expected;
                        if (!match) begin
                            err_pulse_q <= 1'b1;
                            if (err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
                            locked_q <= 1'b0;
`ifdef CNTMON_STICKY_FAULT_EN
                            fault_q <= 1'b1;
                            state   <= FAULT;
`else
                            run     <= '0;
                            state   <= ACQUIRE;
`endif
                        end
                    end
                    FAULT: begin
                        // Samples ignored; only clear leaves this state.
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.expected  = expected_q;
`ifdef CNTMON_STICKY_FAULT_EN
    assign bus.fault     = fault_q;
`else
    assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor (WIDTH=8, LOCK_CNT=4, ERR_W=8).
// Sticky-fault scenarios run only when CNTMON_STICKY_FAULT_EN is defined.
module tb_count_seq_monitor;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    count_seq_monitor_if #(.WIDTH(8), .ERR_W(8)) bus ();

    count_seq_monitor #(.WIDTH(8), .LOCK_CNT(4), .ERR_W(8)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic sample(input logic en, input logic [7:0] v);
        bus.sample_en = en;
        bus.count_in  = v;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_clear(input int n);
        clear = 1'b1;
        bus.sample_en = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    // IDLE sample at start, then four +1 steps; locked after the last one.
    task automatic lock_from(input logic [7:0] start);
        logic [7:0] v;
        v = start;
        for (int i = 0; i < 5; i++) begin
            sample(1'b1, v);
            v = v + 8'd1;
        end
    endtask

    task automatic test_reset;
        clear = 1'b1;
        bus.sample_en = 1'b1;
        bus.count_in  = 8'h55;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        tests_run++;
        if ({bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got locked=%b pulse=%b cnt=%h exp=%h fault=%b, want all 0",
                     bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault);
        end
    endtask

    task automatic test_lock;
        bit pulse_seen = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            sample(1'b1, 8'(i));
            if (bus.err_pulse === 1'b1) pulse_seen = 1'b1;
            if (i == 3) begin
                tests_run++;
                if (bus.locked !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL lock_early: locked=%b after sample 3, want 0", bus.locked);
                end
            end
            if (i == 4) begin
                tests_run++;
                if (bus.locked !== 1'b1 || bus.expected !== 8'd5) begin
                    tests_failed++;
                    $display("FAIL lock_edge: locked=%b exp=%h after sample 4, want 1/05", bus.locked, bus.expected);
                end
            end
        end
        tests_run++;
        if (pulse_seen || bus.err_count !== 8'd0 || bus.expected !== 8'd21) begin
            tests_failed++;
            $display("FAIL lock_run: pulse_seen=%b cnt=%h exp=%h, want 0/00/15", pulse_seen, bus.err_count, bus.expected);
        end
    endtask

    task automatic test_wrap;
        bit pulse_seen = 1'b0;
        logic [7:0] seq [5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        apply_clear(1);
        lock_from(8'hF8);
        foreach (seq[i]) begin
            sample(1'b1, seq[i]);
            if (bus.err_pulse === 1'b1) pulse_seen = 1'b1;
        end
        tests_run++;
        if (pulse_seen || bus.locked !== 1'b1 || bus.expected !== 8'h02 || bus.err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap: pulse_seen=%b locked=%b exp=%h cnt=%h, want 0/1/02/00",
                     pulse_seen, bus.locked, bus.expected, bus.err_count);
        end
    endtask

    task automatic test_hold;
        apply_clear(1);
        lock_from(8'd6);
        for (int i = 0; i < 5; i++) begin
            sample(1'b0, 8'd77);
            tests_run++;
            if ({bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault} !== {1'b1, 1'b0, 8'd0, 8'd11, 1'b0}) begin
                tests_failed++;
                $display("FAIL hold_%0d: locked=%b pulse=%b cnt=%h exp=%h fault=%b, want 1/0/00/0b/0",
                         i, bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault);
            end
        end
        sample(1'b1, 8'd11);
        tests_run++;
        if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b0 || bus.expected !== 8'd12) begin
            tests_failed++;
            $display("FAIL hold_resume: locked=%b pulse=%b exp=%h, want 1/0/0c", bus.locked, bus.err_pulse, bus.expected);
        end
    endtask

`ifndef CNTMON_STICKY_FAULT_EN
    task automatic test_mismatch;
        logic [7:0] seq [5] = '{8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
        apply_clear(1);
        lock_from(8'd6);
        foreach (seq[i]) begin
            sample(1'b1, seq[i]);
            tests_run++;
            if (bus.err_pulse !== (i == 0) || bus.locked !== (i == 4) || bus.err_count !== 8'd1) begin
                tests_failed++;
                $display("FAIL mismatch_%0d: pulse=%b locked=%b cnt=%h, want %b/%b/01",
                         seq[i], bus.err_pulse, bus.locked, bus.err_count, i == 0, i == 4);
            end
        end
        // A held (repeated) value is a mismatch too.
        sample(1'b1, 8'd17);
        tests_run++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'd2 || bus.locked !== 1'b0 || bus.expected !== 8'd18) begin
            tests_failed++;
            $display("FAIL repeat_value: pulse=%b cnt=%h locked=%b exp=%h, want 1/02/0/12",
                     bus.err_pulse, bus.err_count, bus.locked, bus.expected);
        end
    endtask

    task automatic test_saturate;
        logic [7:0] v;
        int pulses = 0;
        apply_clear(1);
        v = 8'd0;
        sample(1'b1, v);
        for (int k = 0; k < 300; k++) begin
            for (int s = 1; s <= 4; s++) sample(1'b1, v + 8'(s));
            v = v + 8'd7;
            sample(1'b1, v);
            if (bus.err_pulse === 1'b1) pulses++;
            if (k == 253 || k == 254) begin
                tests_run++;
                if (bus.err_count !== 8'(k + 1)) begin
                    tests_failed++;
                    $display("FAIL sat_count_%0d: cnt=%h, want %h", k, bus.err_count, 8'(k + 1));
                end
            end
        end
        tests_run++;
        if (pulses != 300 || bus.err_count !== 8'hFF) begin
            tests_failed++;
            $display("FAIL saturate: pulses=%0d cnt=%h, want 300/ff", pulses, bus.err_count);
        end
        for (int s = 1; s <= 4; s++) sample(1'b1, v + 8'(s));
        tests_run++;
        if (bus.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock: locked=%b, want 1", bus.locked);
        end
        // Clear on an edge that would otherwise detect a mismatch.
        clear = 1'b1;
        sample(1'b1, v + 8'd9);
        clear = 1'b0;
        tests_run++;
        if ({bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault} !== 19'd0) begin
            tests_failed++;
            $display("FAIL clear_locked: locked=%b pulse=%b cnt=%h exp=%h fault=%b, want all 0",
                     bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault);
        end
        for (int i = 40; i <= 44; i++) begin
            sample(1'b1, 8'(i));
            if (i >= 43) begin
                tests_run++;
                if (bus.locked !== (i == 44)) begin
                    tests_failed++;
                    $display("FAIL post_clear_lock_%0d: locked=%b, want %b", i, bus.locked, i == 44);
                end
            end
        end
    endtask
`else
    task automatic test_sticky;
        bit pulse_seen = 1'b0;
        apply_clear(1);
        lock_from(8'd6);
        sample(1'b1, 8'd20);
        tests_run++;
        if (bus.fault !== 1'b1 || bus.err_count !== 8'd1 || bus.err_pulse !== 1'b1 || bus.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL sticky_hit: fault=%b cnt=%h pulse=%b locked=%b, want 1/01/1/0",
                     bus.fault, bus.err_count, bus.err_pulse, bus.locked);
        end
        for (int i = 21; i <= 40; i++) begin
            sample(1'b1, 8'(i));
            if (bus.err_pulse === 1'b1) pulse_seen = 1'b1;
        end
        tests_run++;
        if (bus.fault !== 1'b1 || bus.locked !== 1'b0 || bus.err_count !== 8'd1 || pulse_seen || bus.expected !== 8'd21) begin
            tests_failed++;
            $display("FAIL sticky_hold: fault=%b locked=%b cnt=%h pulse_seen=%b exp=%h, want 1/0/01/0/15",
                     bus.fault, bus.locked, bus.err_count, pulse_seen, bus.expected);
        end
        apply_clear(1);
        tests_run++;
        if ({bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault} !== 19'd0) begin
            tests_failed++;
            $display("FAIL sticky_clear: locked=%b pulse=%b cnt=%h exp=%h fault=%b, want all 0",
                     bus.locked, bus.err_pulse, bus.err_count, bus.expected, bus.fault);
        end
    endtask
`endif

    initial begin
        bus.sample_en = 1'b0;
        bus.count_in  = 8'd0;
        test_reset();
        test_lock();
        test_wrap();
        test_hold();
`ifndef CNTMON_STICKY_FAULT_EN
        test_mismatch();
        test_saturate();
`else
        test_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
